// File: rtl/pwm_clk_divider_nch.sv
// -----------------------------------------------------------------------------
// pwm_clk_divider_nch
// Multi-channel programmable clock divider producing the per-leg PWM time
// bases. Each channel has its own counter and a shadowed divisor. A new
// divisor is loaded into the shadow register and only takes over at a period
// boundary, or immediately while the channel is idle, so a running carrier
// never sees a runt period.
//
// Ports:
//   clk         fabric clock
//   reset       asynchronous, active-high reset (released synchronously)
//   enable      per-channel run enable (0 = idle, outputs held low)
//   mode        per-channel output mode: 0 = toggle (div_clk), 1 = tick
//   divider     packed divisors, channel i at [i*DIV_W +: DIV_W]
//   phase       packed start counts, same packing as divider
//   load        per-channel strobe capturing the divider slice into the shadow
//   sync_start  restarts every enabled channel at its (clamped) phase
//   div_clk     divided clock in toggle mode, 0 in tick mode
//   tick        one-cycle terminal-count pulse in tick mode, 0 in toggle mode
//   upd_ack     one-cycle pulse when a pending shadow divisor becomes active
// -----------------------------------------------------------------------------
module pwm_clk_divider_nch #(
    parameter int NCH   = 4,
    parameter int DIV_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       enable,
    input  logic [NCH-1:0]       mode,
    input  logic [NCH*DIV_W-1:0] divider,
    input  logic [NCH*DIV_W-1:0] phase,
    input  logic [NCH-1:0]       load,
    input  logic                 sync_start,
    output logic [NCH-1:0]       div_clk,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       upd_ack
);

    // Reset asserts asynchronously through the set of both stages and is
    // released two clk edges after the input drops.
    logic [1:0] rst_pipe;
    logic       rst_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    assign rst_int = rst_pipe[1];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] act_div;
        logic [DIV_W-1:0] shd_div;
        logic [DIV_W-1:0] div_in;
        logic [DIV_W-1:0] ph_in;
        logic [DIV_W-1:0] start_val;
        logic             pend;
        logic             out_q;
        logic             tick_q;
        logic             upd_q;
        logic             en_q;
        logic             tc;
        logic             start;

        assign div_in    = divider[i*DIV_W +: DIV_W];
        assign ph_in     = phase[i*DIV_W +: DIV_W];
        // Phase is clamped so cnt never starts above the active divisor.
        assign start_val = (ph_in > act_div) ? act_div : ph_in;
        assign tc        = (cnt == act_div);
        assign start     = enable[i] & (~en_q | sync_start);

        always_ff @(posedge clk or posedge rst_int) begin
            if (rst_int) begin
                cnt     <= '0;
                act_div <= '0;
                shd_div <= '0;
                pend    <= 1'b0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
                upd_q   <= 1'b0;
                en_q    <= 1'b0;
            end else begin
                en_q   <= enable[i];
                tick_q <= 1'b0;
                upd_q  <= 1'b0;

                if (load[i]) begin
                    shd_div <= div_in;
                    pend    <= 1'b1;
                end

                if (!enable[i]) begin
                    cnt   <= '0;
                    out_q <= 1'b0;
                    // A load arriving in the same cycle stays pending and is
                    // applied on the following idle cycle.
                    if (pend) begin
                        act_div <= shd_div;
                        pend    <= load[i];
                        upd_q   <= 1'b1;
                    end
                end else if (start) begin
                    cnt   <= start_val;
                    out_q <= 1'b0;
                end else if (tc) begin
                    cnt <= '0;
                    if (mode[i]) begin
                        tick_q <= 1'b1;
                        out_q  <= 1'b0;
                    end else begin
                        out_q <= ~out_q;
                    end
                    // Load coincident with the boundary bypasses the shadow.
                    if (load[i]) begin
                        act_div <= div_in;
                        pend    <= 1'b0;
                        upd_q   <= 1'b1;
                    end else if (pend) begin
                        act_div <= shd_div;
                        pend    <= 1'b0;
                        upd_q   <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + DIV_W'(1);
                    if (mode[i]) begin
                        out_q <= 1'b0;
                    end
                end
            end
        end

        assign div_clk[i] = out_q;
        assign tick[i]    = tick_q;
        assign upd_ack[i] = upd_q;
    end

endmodule
